// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter: accepts a WIDTH-bit word over a valid/ready
// handshake and emits it one bit per enabled clock, LSB- or MSB-first.
module piso_shifter #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             msb_first,
  input  logic             enable,
  output logic             data_out,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  // state   | meaning
  // S_IDLE  | no word in flight, data_out at IDLE_LEVEL
  // S_SHIFT | word in flight, data_out carries a word bit
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sr_shift;
  logic             dir_q, dir_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             load_fire;

  assign load_ready = reset_n & ((state_q == S_IDLE) |
                                 ((state_q == S_SHIFT) & last_q & enable));
  assign load_fire  = load_valid & load_ready;

  // dir=1 drains from the MSB end, dir=0 from the LSB end
  assign sr_shift = dir_q ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load_fire) begin
      sr_d    = data_in;
      dir_d   = msb_first;
      dout_d  = msb_first ? data_in[WIDTH-1] : data_in[0];
      valid_d = 1'b1;
      last_d  = 1'b0;
      cnt_d   = CNT_INIT;
      state_d = S_SHIFT;
    end else if (state_q == S_SHIFT && enable) begin
      if (!last_q) begin
        sr_d   = sr_shift;
        dout_d = dir_q ? sr_shift[WIDTH-1] : sr_shift[0];
        cnt_d  = cnt_q - CW'(1);
        last_d = (cnt_q == CW'(1));
      end else begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        dout_d  = IDLE_LEVEL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= IDLE_LEVEL;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = valid_q;

endmodule

// File: tb/tb_piso_shifter.sv
// Bench for piso_shifter: directed scenarios on an 8-bit instance plus a
// randomized sweep of 8/2/13-bit instances against a word-level model.
module tb_piso_shifter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  en, lv, msb;
  logic [15:0] din [3];
  wire  [2:0]  dout, ov, ol, lr, bsy;

  int n_tests = 0;
  int n_fail  = 0;

  // model: rem = bits of the current word still to be shown, including the one on data_out
  int          wid [3] = '{8, 2, 13};
  logic        idl [3] = '{1'b0, 1'b0, 1'b1};
  int          rem [3] = '{0, 0, 0};
  logic [15:0] mword [3];
  logic        mdir [3];
  logic [15:0] rec [3];
  int          rcnt [3] = '{0, 0, 0};
  int          words [3] = '{0, 0, 0};

  logic s_do, s_ov, s_ol, s_lr;

  piso_shifter #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u_w8 (
    .clk(clk), .reset_n(rst_n), .data_in(din[0][7:0]), .load_valid(lv[0]),
    .load_ready(lr[0]), .msb_first(msb[0]), .enable(en[0]), .data_out(dout[0]),
    .out_valid(ov[0]), .out_last(ol[0]), .busy(bsy[0]));

  piso_shifter #(.WIDTH(2), .IDLE_LEVEL(1'b0)) u_w2 (
    .clk(clk), .reset_n(rst_n), .data_in(din[1][1:0]), .load_valid(lv[1]),
    .load_ready(lr[1]), .msb_first(msb[1]), .enable(en[1]), .data_out(dout[1]),
    .out_valid(ov[1]), .out_last(ol[1]), .busy(bsy[1]));

  piso_shifter #(.WIDTH(13), .IDLE_LEVEL(1'b1)) u_w13 (
    .clk(clk), .reset_n(rst_n), .data_in(din[2][12:0]), .load_valid(lv[2]),
    .load_ready(lr[2]), .msb_first(msb[2]), .enable(en[2]), .data_out(dout[2]),
    .out_valid(ov[2]), .out_last(ol[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: compare all instances with the model, rebuild words, advance the model.
  task automatic tick();
    logic exp_do, exp_ov, exp_ol, exp_lr;
    int pos;
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_ov = (rem[i] != 0);
      exp_ol = (rem[i] == 1);
      if (rem[i] == 0) exp_do = idl[i];
      else if (mdir[i]) exp_do = mword[i][rem[i]-1];
      else exp_do = mword[i][wid[i]-rem[i]];
      exp_lr = rst_n && (rem[i] == 0 || (rem[i] == 1 && en[i]));
      n_tests++;
      if ({dout[i], ov[i], ol[i], lr[i], bsy[i]} !== {exp_do, exp_ov, exp_ol, exp_lr, exp_ov}) begin
        n_fail++;
        $display("FAIL model_outputs dut%0d t=%0t: do/ov/ol/lr/busy got %b required %b",
                 i, $time, {dout[i], ov[i], ol[i], lr[i], bsy[i]},
                 {exp_do, exp_ov, exp_ol, exp_lr, exp_ov});
      end
      if (rst_n && en[i] && ov[i] === 1'b1) begin
        pos = mdir[i] ? wid[i] - 1 - rcnt[i] : rcnt[i];
        if (pos >= 0 && pos < 16) rec[i][pos] = dout[i];
        rcnt[i]++;
        if (ol[i] === 1'b1) begin
          n_tests++;
          if (rec[i] !== mword[i] || rcnt[i] != wid[i]) begin
            n_fail++;
            $display("FAIL word_rebuild dut%0d t=%0t: got %h (%0d bits) required %h (%0d bits)",
                     i, $time, rec[i], rcnt[i], mword[i], wid[i]);
          end
          words[i]++;
          rcnt[i] = 0;
          rec[i]  = '0;
        end
      end
      if (!rst_n) begin
        rem[i]  = 0;
        rcnt[i] = 0;
        rec[i]  = '0;
      end else if (lv[i] && exp_lr) begin
        mword[i] = din[i] & ((16'h1 << wid[i]) - 16'h1);
        mdir[i]  = msb[i];
        rem[i]   = wid[i];
      end else if (en[i] && rem[i] > 0) begin
        rem[i]--;
      end
    end
    s_do = dout[0]; s_ov = ov[0]; s_ol = ol[0]; s_lr = lr[0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (s_lr !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b required 0", s_lr); end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (s_lr !== 1'b1 || s_ov !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: lr/ov got %b%b required 10", s_lr, s_ov);
    end
    din[0] = 16'h00A5; msb[0] = 1'b0; lv[0] = 1'b1; en[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (s_lr !== 1'b0 || s_ov !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_cycle: lr/ov got %b%b required 01", s_lr, s_ov);
    end
    tick();
    n_tests++;
    if ({s_do, s_ov, s_ol, s_lr} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_word: do/ov/ol/lr got %b required 0000", {s_do, s_ov, s_ol, s_lr});
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (s_lr !== 1'b1 || s_ov !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: lr/ov got %b%b required 10", s_lr, s_ov);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_lsb_first();
    logic [7:0] got, lasts;
    din[0] = 16'h00A5; msb[0] = 1'b0; lv[0] = 1'b1; en[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      got[k] = s_do; lasts[k] = s_ol;
    end
    tick();
    n_tests++;
    if (got !== 8'hA5) begin n_fail++; $display("FAIL lsb_bits: got %h required a5", got); end
    n_tests++;
    if (lasts !== 8'h80) begin n_fail++; $display("FAIL lsb_last: got %b required 10000000", lasts); end
    n_tests++;
    if (s_ov !== 1'b0) begin n_fail++; $display("FAIL lsb_ninth_valid: got %b required 0", s_ov); end
  endtask

  task automatic test_msb_first();
    logic [7:0] got;
    logic [7:0] words_in [2] = '{8'hA5, 8'h0F};
    for (int w = 0; w < 2; w++) begin
      din[0] = {8'h00, words_in[w]}; msb[0] = 1'b1; lv[0] = 1'b1; en[0] = 1'b1;
      tick();
      lv[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (k == 3) msb[0] = 1'b0;
        tick();
        got[7-k] = s_do;
      end
      n_tests++;
      if (got !== words_in[w]) begin
        n_fail++; $display("FAIL msb_bits word%0d: got %h required %h", w, got, words_in[w]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq, ovs, lrs;
    din[0] = 16'h0081; msb[0] = 1'b0; lv[0] = 1'b1; en[0] = 1'b1;
    tick();
    din[0] = 16'h007E;
    for (int k = 0; k < 16; k++) begin
      tick();
      seq[k] = s_do; ovs[k] = s_ov; lrs[k] = s_lr;
      if (k == 7) lv[0] = 1'b0;
    end
    tick();
    n_tests++;
    if (seq !== 16'h7E81) begin n_fail++; $display("FAIL b2b_bits: got %h required 7e81", seq); end
    n_tests++;
    if (ovs !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_valid: got %h required ffff", ovs); end
    n_tests++;
    if (lrs !== 16'h8080) begin n_fail++; $display("FAIL b2b_ready: got %h required 8080", lrs); end
    n_tests++;
    if (s_ov !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b required 0", s_ov); end
  endtask

  task automatic test_stall();
    logic [7:0]  word = 8'hC3;
    logic [12:0] pat  = 13'b1_0011_1000_1111;
    int idx = 0;
    int dur = 0;
    din[0] = {8'h00, word}; msb[0] = 1'b0; lv[0] = 1'b1; en[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    for (int c = 0; c < 13; c++) begin
      en[0] = pat[c];
      tick();
      if (s_ov === 1'b1) dur++;
      n_tests++;
      if (s_do !== word[idx] || s_ol !== (idx == 7) || s_lr !== (idx == 7 && pat[c])) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: do/ol/lr got %b%b%b required %b%b%b", c, s_do, s_ol, s_lr,
                 word[idx], (idx == 7), (idx == 7 && pat[c]));
      end
      if (pat[c]) idx++;
    end
    en[0] = 1'b1;
    tick();
    n_tests++;
    if (s_ov !== 1'b0 || dur != 13) begin
      n_fail++; $display("FAIL stall_duration: got %0d cycles ov=%b required 13 cycles ov=0", dur, s_ov);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_sweep();
    int w1, w2;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        en[i]  = ($urandom_range(0, 3) != 0);
        lv[i]  = ($urandom_range(0, 2) != 0);
        msb[i] = $urandom_range(0, 1);
        din[i] = 16'($urandom);
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    en = '0; lv = '0;
    tick();
    w1 = words[1]; w2 = words[2];
    n_tests++;
    if (w1 < 50 || w2 < 20) begin
      n_fail++; $display("FAIL sweep_word_count: got %0d/%0d words required at least 50/20", w1, w2);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = '0; lv = '0; msb = '0;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; mword[i] = '0; mdir[i] = 1'b0; rec[i] = '0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_stall();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_shifter.md
# piso_shifter

Parametrised parallel-in/serial-out shifter, the successor to the 4-bit PISO. It accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled clock, LSB- or MSB-first, with per-bit valid and last-bit flags. Back-to-back words stream without a gap. It sits between parallel datapath producers and bit-serial links or consumers in the same clock domain.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range ≥ 2.
- IDLE_LEVEL, 1'b0, value driven on data_out when no word is being shifted.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- data_in  in  WIDTH  parallel word; sampled only on load handshake.
- load_valid  in  1  producer has a word on data_in.
- load_ready  out  1  shifter can accept a word this cycle (combinational).
- msb_first  in  1  bit order for the word being loaded; sampled with data_in.
- enable  in  1  consumer takes the current serial bit this cycle; 0 = stall.
- data_out  out  1  current serial bit (registered).
- out_valid  out  1  data_out carries a word bit (registered).
- out_last  out  1  current bit is the final bit of the word (registered).
- busy  out  1  word in flight; equals out_valid.

## Operation
- State: IDLE, SHIFT. Internal: shift register sr[WIDTH-1:0], direction flag dir, bit counter cnt of width $clog2(WIDTH), counting bits still to emit after the current one.
- Reset (reset_n=0 at a clock edge): state←IDLE, sr←0, cnt←0, dir←0, data_out←IDLE_LEVEL, out_valid←0, out_last←0. load_ready is forced to 0 while reset_n=0.
- load_ready = reset_n & (IDLE | (SHIFT & out_last & enable)).
- Load (load_valid & load_ready): latch data_in and msb_first. data_out←data_in[0] (LSB-first) or data_in[WIDTH-1] (MSB-first). out_valid←1, out_last←0, cnt←WIDTH-1, state←SHIFT.
- SHIFT with enable=1 and out_last=0: shift sr toward the emitted end, data_out←next bit, cnt←cnt-1, out_last←(cnt==1).
- SHIFT with enable=1 and out_last=1: the word is complete. With a simultaneous load, the new word loads as above with no idle cycle. Otherwise state←IDLE, out_valid←0, out_last←0, data_out←IDLE_LEVEL.
- SHIFT with enable=0: all outputs and state hold. load_ready=0 even if out_last=1.
- IDLE with enable=1 and no load: no effect.
- msb_first changes while in SHIFT: ignored until the next load.
- load_valid without load_ready: ignored. The producer holds data_in until accepted.

## Timing
- Load-to-first-bit latency: 1 cycle. The first bit is visible after the accepting edge.
- A word occupies exactly WIDTH enabled cycles. Stall cycles add 1:1.
- Continuous enable with continuous load_valid gives 100% throughput: one bit per clock, out_valid never drops.
- out_last is high for exactly the final bit. It stays high across stalls of that bit.
- Reset mid-word: the word is discarded. Outputs take their reset values on the reset edge. The first cycle with reset_n=1 is IDLE with load_ready=1.
- Reset takes priority over load and enable in the same cycle.

## Test plan
- Reset: hold reset_n=0 for 2 cycles during an active word → data_out=IDLE_LEVEL, out_valid=0, out_last=0, load_ready=0. First cycle after release: load_ready=1.
- LSB-first, WIDTH=8: load 0xA5 with msb_first=0 and enable held at 1 → data_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles. out_last is high on the 8th bit only. out_valid=0 on the 9th cycle.
- MSB-first: load 0xA5 with msb_first=1 → data_out 1,0,1,0,0,1,0,1 (MSB first). Then load 0x0F → 0,0,0,0,1,1,1,1. msb_first toggled mid-word has no effect.
- Back-to-back: load_valid held with 0x81 then 0x7E, enable=1 → 16 contiguous valid bits. load_ready pulses exactly on the out_last cycle. No gap between words.
- Stall: during word 0xC3, drop enable for 3 cycles on bit 4 and for 2 cycles on the last bit → data_out and out_last hold. load_ready stays 0 during the stall. Total word duration is 13 cycles.
- Parameter sweep: WIDTH=2 and WIDTH=13 with random words, random enable and random load_valid → the scoreboard-reconstructed words match the loaded words. out_last occurs once per word.
